// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit slice.
package lsu_pkg;

    localparam int WORD_W = 32;

    // Access size encodings carried on req_size.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } state_t;

endpackage

// File: rtl/lsu_if.sv
// Core request/response channel and word-memory port of the load/store unit.
//
// Handshake: a request transfers on the rising edge where req_valid and
// req_ready are both high; req_valid may be raised at any time and is ignored
// while req_ready is low (nothing is queued). resp_valid is a one-cycle pulse
// with no back-pressure; resp_rdata/resp_err are meaningful while it is high.
interface lsu_req_if;
    import lsu_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [WORD_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic              resp_valid;
    logic [WORD_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// Single-cycle word memory port: read data returns combinationally while
// mem_re is high, a write commits in the cycle mem_we is high.
interface lsu_mem_if;
    import lsu_pkg::*;

    logic [WORD_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              mem_re;
    logic              mem_we;
    logic [WORD_W-1:0] mem_rdata;

    modport master (
        output mem_addr, mem_wdata, mem_re, mem_we,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_re, mem_we,
        output mem_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Little-endian lane selection: extends a loaded lane and merges a store lane.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]        offset,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    input  logic [WORD_W-1:0] rword,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] load_val,
    output logic [WORD_W-1:0] merged
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = rword[{offset, 3'b000} +: 8];
    assign half_lane = rword[{offset[1], 4'b0000} +: 16];

    // Extend the addressed lane for loads; overlay the store lane on the read word.
    always_comb begin
        load_val = rword;
        merged   = wdata;
        case (size)
            SZ_BYTE: begin
                load_val = is_unsigned ? {24'b0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
                merged   = rword;
                merged[{offset, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_val = is_unsigned ? {16'b0, half_lane} : {{16{half_lane[15]}}, half_lane};
                merged   = rword;
                merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: begin
                load_val = rword;
                merged   = wdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte/half/word load-store initiator for a single-cycle word memory.
// Sub-word stores read the word first and write back the merged word.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DEPTH_WORDS = 32
) (
    input  logic       clk,
    input  logic       rst,
    lsu_req_if.slave   req,
    lsu_mem_if.master  mem,
    output state_t     dbg_state
);

    localparam logic [WORD_W-1:0] DEPTH_LIM = WORD_W'(DEPTH_WORDS);

    state_t            state, state_next;
    logic              lat_write, lat_unsigned;
    logic [1:0]        lat_size;
    logic [WORD_W-1:0] lat_addr, lat_wdata, rd_word;
    logic [WORD_W-1:0] resp_rdata_q;
    logic              resp_err_q;
    logic              req_err, accept;
    logic [WORD_W-1:0] align_rword, load_val, merged;

    assign accept = req.req_valid && (state == IDLE);

    // A request is rejected at accept for a reserved size, misalignment or an
    // out-of-range word index; such a request never reaches the memory port.
    assign req_err = (req.req_size == SZ_RSVD)
                  || (req.req_size == SZ_HALF && req.req_addr[0])
                  || (req.req_size == SZ_WORD && req.req_addr[1:0] != 2'b00)
                  || ({2'b00, req.req_addr[31:2]} >= DEPTH_LIM);

    // Loads extract from the live read data in RD; the RMW merge in WR uses the
    // word captured at the end of RD.
    assign align_rword = (state == RD) ? mem.mem_rdata : rd_word;

    lsu_align u_align (
        .offset      (lat_addr[1:0]),
        .size        (lat_size),
        .is_unsigned (lat_unsigned),
        .rword       (align_rword),
        .wdata       (lat_wdata),
        .load_val    (load_val),
        .merged      (merged)
    );

    assign req.resp_rdata = resp_rdata_q;
    assign req.resp_err   = resp_err_q;
    assign dbg_state      = state;

    // State register; reset aborts any in-flight access immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Request latch, read-word capture and registered response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_write    <= 1'b0;
            lat_unsigned <= 1'b0;
            lat_size     <= SZ_BYTE;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            rd_word      <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else if (accept) begin
            lat_write    <= req.req_write;
            lat_unsigned <= req.req_unsigned;
            lat_size     <= req.req_size;
            lat_addr     <= req.req_addr;
            lat_wdata    <= req.req_wdata;
            resp_rdata_q <= '0;
            resp_err_q   <= req_err;
        end else if (state == RD) begin
            rd_word <= mem.mem_rdata;
            if (!lat_write) resp_rdata_q <= load_val;
        end
    end

    // Next-state selection and per-state port drive.
    always_comb begin
        state_next     = state;
        req.req_ready  = 1'b0;
        req.resp_valid = 1'b0;
        mem.mem_re     = 1'b0;
        mem.mem_we     = 1'b0;
        mem.mem_addr   = '0;
        mem.mem_wdata  = '0;
        case (state)
            IDLE: begin
                req.req_ready = 1'b1;
                if (req.req_valid) begin
                    if (req_err)                   state_next = RESP;
                    else if (!req.req_write)       state_next = RD;
                    else if (req.req_size == SZ_WORD) state_next = WR;
                    else                           state_next = RD;
                end
            end
            RD: begin
                mem.mem_re   = 1'b1;
                mem.mem_addr = {lat_addr[31:2], 2'b00};
                state_next   = lat_write ? WR : RESP;
            end
            WR: begin
                mem.mem_we    = 1'b1;
                mem.mem_addr  = {lat_addr[31:2], 2'b00};
                mem.mem_wdata = merged;
                state_next    = RESP;
            end
            RESP: begin
                req.resp_valid = 1'b1;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset abort, back-to-back
// issue and randomized traffic against a byte-array reference model.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_req_if rq ();
    lsu_mem_if mb ();
    state_t    dbg_state;

    load_store_unit #(.DEPTH_WORDS(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (rq.slave),
        .mem       (mb.master),
        .dbg_state (dbg_state)
    );

    // Attached memory: 32 words, combinational read, write on posedge.
    logic [31:0] mem [32];
    logic        mem_clear;
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
            mem[0] <= 32'h0000000F;
            mem[1] <= 32'h0000000A;
        end else if (mb.mem_we) begin
            mem[mb.mem_addr[6:2]] <= mb.mem_wdata;
        end
    end
    assign mb.mem_rdata = mem[mb.mem_addr[6:2]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: the memory as a flat byte array, little-endian.
    logic [7:0] ref_b [128];

    function automatic int ref_nbytes(input logic [1:0] sz);
        return 1 << sz;
    endfunction

    function automatic logic ref_err(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'b11) return 1'b1;
        if ((a % ref_nbytes(sz)) != 0) return 1'b1;
        if ((a / 4) >= 32) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic u, input logic [31:0] a);
        longint v = 0;
        int n = ref_nbytes(sz);
        for (int i = 0; i < n; i++) v += longint'(ref_b[int'(a) + i]) << (8 * i);
        if (!u && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] t;
        for (int i = 0; i < ref_nbytes(sz); i++) begin
            t = wd >> (8 * i);
            ref_b[int'(a) + i] = t[7:0];
        end
    endtask

    // Issue one request and observe it through to its response.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output int re_n, output int we_n, output logic [31:0] wword);
        int guard = 0;
        logic seen = 1'b0;
        @(negedge clk);
        while (!rq.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("req_ready_idle", 32'(rq.req_ready), 32'd1);
        rq.req_write    = w;
        rq.req_size     = sz;
        rq.req_unsigned = u;
        rq.req_addr     = a;
        rq.req_wdata    = wd;
        rq.req_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rq.req_valid = 1'b0;
        lat = 1; re_n = 0; we_n = 0; wword = '0; rdata = '0; err = 1'b0;
        while (lat <= 10) begin
            if (mb.mem_re) re_n++;
            if (mb.mem_we) begin
                we_n++;
                wword = mb.mem_wdata;
            end
            if (mb.mem_re || mb.mem_we) begin
                check("re_we_exclusive", 32'(mb.mem_re && mb.mem_we), 32'd0);
                check("mem_addr", mb.mem_addr, {a[31:2], 2'b00});
            end
            if (rq.resp_valid) begin
                rdata = rq.resp_rdata;
                err   = rq.resp_err;
                seen  = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        check("resp_seen", 32'(seen), 32'd1);
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        int          exp_re;
        int          exp_we;
        logic [31:0] exp_ww;
    } vec_t;

    vec_t tbl [20];

    logic [31:0] rdata, wword, exp_rd;
    logic        err, exp_err;
    int          lat, re_n, we_n;

    initial begin
        // Directed vectors in issue order; memory starts word0=0xF, word1=0xA.
        tbl[0]  = '{1'b0, SZ_WORD, 1'b0, 32'h04, 32'h0,        32'h0000000A, 1'b0, 2, 1, 0, 32'h0};
        tbl[1]  = '{1'b1, SZ_BYTE, 1'b0, 32'h01, 32'h80,       32'h0,        1'b0, 3, 1, 1, 32'h0000800F};
        tbl[2]  = '{1'b0, SZ_BYTE, 1'b0, 32'h01, 32'h0,        32'hFFFFFF80, 1'b0, 2, 1, 0, 32'h0};
        tbl[3]  = '{1'b0, SZ_BYTE, 1'b1, 32'h01, 32'h0,        32'h00000080, 1'b0, 2, 1, 0, 32'h0};
        tbl[4]  = '{1'b1, SZ_HALF, 1'b0, 32'h06, 32'hBEEF,     32'h0,        1'b0, 3, 1, 1, 32'hBEEF000A};
        tbl[5]  = '{1'b0, SZ_HALF, 1'b0, 32'h06, 32'h0,        32'hFFFFBEEF, 1'b0, 2, 1, 0, 32'h0};
        tbl[6]  = '{1'b0, SZ_HALF, 1'b1, 32'h06, 32'h0,        32'h0000BEEF, 1'b0, 2, 1, 0, 32'h0};
        tbl[7]  = '{1'b0, SZ_WORD, 1'b0, 32'h02, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0};
        tbl[8]  = '{1'b1, SZ_HALF, 1'b0, 32'h03, 32'h1234,     32'h0,        1'b1, 1, 0, 0, 32'h0};
        tbl[9]  = '{1'b0, SZ_RSVD, 1'b0, 32'h00, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0};
        tbl[10] = '{1'b0, SZ_WORD, 1'b0, 32'h80, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0};
        tbl[11] = '{1'b1, SZ_BYTE, 1'b0, 32'h03, 32'h1FF,      32'h0,        1'b0, 3, 1, 1, 32'hFF00800F};
        tbl[12] = '{1'b0, SZ_BYTE, 1'b0, 32'h03, 32'h0,        32'hFFFFFFFF, 1'b0, 2, 1, 0, 32'h0};
        tbl[13] = '{1'b0, SZ_HALF, 1'b1, 32'h02, 32'h0,        32'h0000FF00, 1'b0, 2, 1, 0, 32'h0};
        tbl[14] = '{1'b1, SZ_WORD, 1'b0, 32'h0C, 32'hCAFEF00D, 32'h0,        1'b0, 2, 0, 1, 32'hCAFEF00D};
        tbl[15] = '{1'b0, SZ_WORD, 1'b0, 32'h0C, 32'h0,        32'hCAFEF00D, 1'b0, 2, 1, 0, 32'h0};
        tbl[16] = '{1'b0, SZ_HALF, 1'b0, 32'h0E, 32'h0,        32'hFFFFCAFE, 1'b0, 2, 1, 0, 32'h0};
        tbl[17] = '{1'b0, SZ_BYTE, 1'b1, 32'h0D, 32'h0,        32'h000000F0, 1'b0, 2, 1, 0, 32'h0};
        tbl[18] = '{1'b1, SZ_WORD, 1'b0, 32'h80, 32'h55,       32'h0,        1'b1, 1, 0, 0, 32'h0};
        tbl[19] = '{1'b0, SZ_WORD, 1'b0, 32'h7C, 32'h0,        32'h0,        1'b0, 2, 1, 0, 32'h0};

        for (int i = 0; i < 128; i++) ref_b[i] = 8'h0;
        ref_b[0] = 8'h0F;
        ref_b[4] = 8'h0A;

        // Clock/reset block.
        rq.req_valid = 1'b0; rq.req_write = 1'b0; rq.req_size = SZ_WORD;
        rq.req_unsigned = 1'b0; rq.req_addr = '0; rq.req_wdata = '0;
        rst = 1'b1;
        mem_clear = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mem_clear = 1'b0;
        rst = 1'b0;

        check("rst_req_ready",  32'(rq.req_ready), 32'd1);
        check("rst_resp_valid", 32'(rq.resp_valid), 32'd0);
        check("rst_resp_rdata", rq.resp_rdata, 32'd0);
        check("rst_resp_err",   32'(rq.resp_err), 32'd0);
        check("rst_mem_re",     32'(mb.mem_re), 32'd0);
        check("rst_mem_we",     32'(mb.mem_we), 32'd0);
        check("rst_mem_addr",   mb.mem_addr, 32'd0);
        check("rst_mem_wdata",  mb.mem_wdata, 32'd0);
        check("rst_state",      32'(dbg_state), 32'(IDLE));

        // Directed table.
        for (int i = 0; i < 20; i++) begin
            do_req(tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].wd, rdata, err, lat, re_n, we_n, wword);
            check($sformatf("vec%0d_rdata", i), rdata, tbl[i].exp_rd);
            check($sformatf("vec%0d_err", i), 32'(err), 32'(tbl[i].exp_err));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(tbl[i].exp_lat));
            check($sformatf("vec%0d_re_count", i), 32'(re_n), 32'(tbl[i].exp_re));
            check($sformatf("vec%0d_we_count", i), 32'(we_n), 32'(tbl[i].exp_we));
            if (tbl[i].exp_we != 0) check($sformatf("vec%0d_wr_word", i), wword, tbl[i].exp_ww);
            if (tbl[i].w && !tbl[i].exp_err) ref_store(tbl[i].sz, tbl[i].a, tbl[i].wd);
        end

        // Reset during the RD cycle of a byte store: no write, no response.
        begin
            int we_seen = 0, resp_seen = 0;
            @(negedge clk);
            rq.req_write = 1'b1; rq.req_size = SZ_BYTE; rq.req_unsigned = 1'b0;
            rq.req_addr = 32'h0; rq.req_wdata = 32'h55; rq.req_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rq.req_valid = 1'b0;
            check("abort_in_rd", 32'(mb.mem_re), 32'd1);
            rst = 1'b1;
            #1;
            check("abort_we_async", 32'(mb.mem_we), 32'd0);
            check("abort_ready_async", 32'(rq.req_ready), 32'd1);
            @(negedge clk);
            rst = 1'b0;
            for (int k = 0; k < 6; k++) begin
                if (mb.mem_we) we_seen++;
                if (rq.resp_valid) resp_seen++;
                @(negedge clk);
            end
            check("abort_we_count", 32'(we_seen), 32'd0);
            check("abort_resp_count", 32'(resp_seen), 32'd0);
            check("abort_ready_after", 32'(rq.req_ready), 32'd1);
            check("abort_word0", mem[0], {ref_b[3], ref_b[2], ref_b[1], ref_b[0]});
        end

        // Back-to-back: store then load with req_valid held high.
        begin
            int a1 = -1, a2 = -1, n_acc = 0, g = 0;
            logic got = 1'b0;
            rq.req_write = 1'b1; rq.req_size = SZ_WORD; rq.req_unsigned = 1'b0;
            rq.req_addr = 32'h8; rq.req_wdata = 32'h12345678; rq.req_valid = 1'b1;
            for (int k = 0; k < 20 && n_acc < 2; k++) begin
                if (rq.req_ready) begin
                    if (n_acc == 0) a1 = cyc + 1;
                    else            a2 = cyc + 1;
                    n_acc++;
                end
                @(posedge clk);
                @(negedge clk);
                if (n_acc == 1) begin
                    rq.req_write = 1'b0; rq.req_wdata = 32'h0;
                end
                if (n_acc == 2) rq.req_valid = 1'b0;
            end
            rq.req_valid = 1'b0;
            ref_store(SZ_WORD, 32'h8, 32'h12345678);
            check("b2b_accepts", 32'(n_acc), 32'd2);
            check("b2b_gap", 32'(a2 - a1), 32'd3);
            while (g < 10 && !got) begin
                if (rq.resp_valid) begin
                    got = 1'b1;
                    rdata = rq.resp_rdata;
                end else begin
                    @(negedge clk);
                    g++;
                end
            end
            check("b2b_resp_seen", 32'(got), 32'd1);
            check("b2b_load", rdata, ref_load(SZ_WORD, 1'b0, 32'h8));
        end

        // Randomized traffic against the reference model.
        for (int i = 0; i < 80; i++) begin
            logic        w, u;
            logic [1:0]  sz;
            logic [31:0] a, wd;
            int          exp_lat, exp_re, exp_we;
            w  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            u  = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(128, 300)) : 32'($urandom_range(0, 127));
            if ($urandom_range(0, 3) != 0 && sz != 2'b11) a = a & ~((32'd1 << sz) - 32'd1);
            wd = $urandom;
            exp_err = ref_err(sz, a);
            exp_rd  = (exp_err || w) ? 32'h0 : ref_load(sz, u, a);
            exp_lat = exp_err ? 1 : ((w && sz != SZ_WORD) ? 3 : 2);
            exp_re  = (exp_err || (w && sz == SZ_WORD)) ? 0 : 1;
            exp_we  = (exp_err || !w) ? 0 : 1;
            do_req(w, sz, u, a, wd, rdata, err, lat, re_n, we_n, wword);
            check($sformatf("rnd%0d_rdata", i), rdata, exp_rd);
            check($sformatf("rnd%0d_err", i), 32'(err), 32'(exp_err));
            check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(exp_lat));
            check($sformatf("rnd%0d_re_count", i), 32'(re_n), 32'(exp_re));
            check($sformatf("rnd%0d_we_count", i), 32'(we_n), 32'(exp_we));
            if (w && !exp_err) ref_store(sz, a, wd);
        end

        // Final memory image versus the reference bytes.
        @(negedge clk);
        for (int i = 0; i < 32; i++)
            check($sformatf("mem_word%0d", i), mem[i],
                  {ref_b[4*i+3], ref_b[4*i+2], ref_b[4*i+1], ref_b[4*i]});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
